// File: rtl/tracker_ctrl.sv
// Two-axis light tracker: samples four LDRs through a shared ADC handshake each update
// period and nudges the pan/tilt servo targets toward the brighter side.
module tracker_ctrl #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int UPDATE_MS      = 100,
  parameter int DEADBAND       = 64,
  parameter int STEP           = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        adc_req,
  output logic [1:0]  adc_ch,
  input  logic        adc_ack,
  input  logic [11:0] adc_data,
  output logic [7:0]  pan_pos,
  output logic [7:0]  tilt_pos,
  output logic        busy,
  output logic        timeout_err
);

  localparam int UPDATE_CYCLES = (CLK_FREQ_HZ / 1000) * UPDATE_MS;
  localparam int TW = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(UPDATE_CYCLES - 1);
  localparam logic [OW-1:0] TO_LAST = OW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [13:0] DB_POS = 14'(DEADBAND);
  localparam logic signed [13:0] DB_NEG = 14'(-DEADBAND);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] CENTRE = 8'd127;

  typedef enum logic [2:0] {
    WAIT_TICK,
    REQ,
    WAIT_ACK,
    CALC,
    UPDATE
  } state_t;

  state_t state, state_next;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [1:0]    idx, idx_next;
  logic          gap, gap_next;
  logic [OW-1:0] to_cnt;
  logic          capture;
  logic          to_fire;
  logic          err_q;
  logic [11:0]   samples [4];
  logic signed [13:0] h_q, v_q;
  logic [12:0]   sum_left, sum_right, sum_top, sum_bottom;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT_TICK;
      idx   <= 2'd0;
      gap   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      gap   <= gap_next;
      err_q <= to_fire;
    end
  end

  // After each ack the request drops for one cycle (gap) so the ADC sees a
  // fresh rising request for the next channel.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    gap_next   = 1'b0;
    capture    = 1'b0;
    to_fire    = 1'b0;
    adc_req    = 1'b0;
    case (state)
      WAIT_TICK: begin
        if (tick && enable) begin
          state_next = REQ;
          idx_next   = 2'd0;
        end
      end
      REQ: begin
        adc_req = !gap;
        if (!gap) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        adc_req = 1'b1;
        if (adc_ack) begin
          capture = 1'b1;
          if (idx == 2'd3) begin
            state_next = CALC;
          end else begin
            state_next = REQ;
            idx_next   = idx + 2'd1;
            gap_next   = 1'b1;
          end
        end else if (to_cnt >= TO_LAST) begin
          state_next = WAIT_TICK;
          to_fire    = 1'b1;
        end
      end
      CALC:    state_next = UPDATE;
      UPDATE:  state_next = WAIT_TICK;
      default: state_next = WAIT_TICK;
    endcase
  end

  assign adc_ch      = adc_req ? idx : 2'd0;
  assign busy        = (state != WAIT_TICK);
  assign timeout_err = err_q;

  // Counts cycles since the request rose, so the abort lands TIMEOUT_CYCLES after it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (adc_req) begin
      to_cnt <= to_cnt + OW'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) samples[i] <= '0;
    end else if (capture) begin
      samples[idx] <= adc_data;
    end
  end

  assign sum_left   = {1'b0, samples[0]} + {1'b0, samples[2]};
  assign sum_right  = {1'b0, samples[1]} + {1'b0, samples[3]};
  assign sum_top    = {1'b0, samples[0]} + {1'b0, samples[1]};
  assign sum_bottom = {1'b0, samples[2]} + {1'b0, samples[3]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (state == CALC) begin
      h_q <= $signed({1'b0, sum_left}) - $signed({1'b0, sum_right});
      v_q <= $signed({1'b0, sum_top}) - $signed({1'b0, sum_bottom});
    end
  end

  // Ninth bit of the sum/difference flags overflow past 255 or below 0.
  function automatic logic [7:0] step_pos(input logic [7:0] pos, input logic signed [13:0] diff);
    logic [8:0] up;
    logic [8:0] dn;
    up = {1'b0, pos} + STEP9;
    dn = {1'b0, pos} - STEP9;
    step_pos = pos;
    if (diff > DB_POS) begin
      step_pos = up[8] ? 8'd255 : up[7:0];
    end else if (diff < DB_NEG) begin
      step_pos = dn[8] ? 8'd0 : dn[7:0];
    end
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pan_pos  <= CENTRE;
      tilt_pos <= CENTRE;
    end else if (state == UPDATE) begin
      pan_pos  <= step_pos(pan_pos, h_q);
      tilt_pos <= step_pos(tilt_pos, v_q);
    end
  end

endmodule

// File: tb/tb_tracker_ctrl.sv
// Directed bench for tracker_ctrl with a 10-cycle update period and a behavioural
// ADC that answers each request three clock edges after it rises.
module tb_tracker_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        adc_req;
  logic [1:0]  adc_ch;
  logic        adc_ack;
  logic [11:0] adc_data;
  logic [7:0]  pan_pos;
  logic [7:0]  tilt_pos;
  logic        busy;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  logic [11:0] adc_val [4];
  bit   stall [4];
  int   ch_log [$];
  bit   seq_ok;

  always #5 clk = ~clk;

  tracker_ctrl #(
    .CLK_FREQ_HZ(1000),
    .UPDATE_MS(10),
    .DEADBAND(64),
    .STEP(2),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .adc_req(adc_req),
    .adc_ch(adc_ch),
    .adc_ack(adc_ack),
    .adc_data(adc_data),
    .pan_pos(pan_pos),
    .tilt_pos(tilt_pos),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  // ADC front end: a stalled channel is never answered.
  initial begin : adc_model
    int ch;
    adc_ack  = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      if (reset_n && adc_req && !stall[adc_ch]) begin
        ch = int'(adc_ch);
        repeat (2) @(negedge clk);
        if (reset_n && adc_req && adc_ch == 2'(ch)) begin
          adc_data = adc_val[ch];
          adc_ack  = 1'b1;
          ch_log.push_back(ch);
          @(negedge clk);
          adc_ack = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int log_code();
    int code = 0;
    foreach (ch_log[i]) code = code * 10 + ch_log[i] + 1;
    return code;
  endfunction

  task automatic set_vals(input int tl, input int tr, input int bl, input int br);
    adc_val[0] = 12'(tl);
    adc_val[1] = 12'(tr);
    adc_val[2] = 12'(bl);
    adc_val[3] = 12'(br);
  endtask

  // Allows exactly one sequence to start, then waits for it to finish.
  task automatic run_seq();
    int n;
    seq_ok = 1'b1;
    ch_log.delete();
    enable = 1'b1;
    n = 0;
    while (!busy && n < 40) begin @(posedge clk); #1; n++; end
    if (!busy) seq_ok = 1'b0;
    enable = 1'b0;
    n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    if (busy) seq_ok = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pan_pos !== 8'd127) begin errors++; $display("[TB] FAIL reset_pan: got %0d expected 127", pan_pos); end
    checks++; if (tilt_pos !== 8'd127) begin errors++; $display("[TB] FAIL reset_tilt: got %0d expected 127", tilt_pos); end
    checks++; if ({adc_req, adc_ch} !== 3'b000) begin errors++; $display("[TB] FAIL reset_adc: got req=%b ch=%0d expected 0/0", adc_req, adc_ch); end
    checks++; if ({busy, timeout_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got busy=%b err=%b expected 0/0", busy, timeout_err); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_equal_light();
    set_vals(1000, 1000, 1000, 1000);
    run_seq();
    checks++; if (seq_ok !== 1'b1) begin errors++; $display("[TB] FAIL equal_seq_done: got %b expected 1", seq_ok); end
    checks++; if (log_code() !== 1234) begin errors++; $display("[TB] FAIL equal_ch_order: got code %0d expected 1234", log_code()); end
    checks++; if ({pan_pos, tilt_pos} !== {8'd127, 8'd127}) begin errors++; $display("[TB] FAIL equal_pos: got %0d/%0d expected 127/127", pan_pos, tilt_pos); end
  endtask

  task automatic test_update_timing();
    int n;
    set_vals(2000, 1000, 2000, 1000);
    ch_log.delete();
    enable = 1'b1;
    n = 0;
    while (!(adc_ack && ch_log.size() == 4) && n < 80) begin
      @(posedge clk); #1; n++;
      if (busy) enable = 1'b0;
    end
    enable = 1'b0;
    checks++; if (!(adc_ack && ch_log.size() == 4)) begin errors++; $display("[TB] FAIL timing_fourth_ack: got %0d acks expected 4", ch_log.size()); end
    @(posedge clk); #1;
    checks++; if (pan_pos !== 8'd127) begin errors++; $display("[TB] FAIL timing_early: got pan %0d one cycle after ack expected 127", pan_pos); end
    @(posedge clk); #1;
    checks++; if (pan_pos !== 8'd129) begin errors++; $display("[TB] FAIL timing_pan: got %0d two cycles after ack expected 129", pan_pos); end
    checks++; if (tilt_pos !== 8'd127) begin errors++; $display("[TB] FAIL timing_tilt: got %0d expected 127", tilt_pos); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timing_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_deadband();
    set_vals(1033, 1000, 1031, 1000);
    run_seq();
    checks++; if ({seq_ok, pan_pos, tilt_pos} !== {1'b1, 8'd129, 8'd127}) begin errors++; $display("[TB] FAIL deadband_64: got done=%b pos %0d/%0d expected 1 129/127", seq_ok, pan_pos, tilt_pos); end
    set_vals(1034, 1000, 1031, 1000);
    run_seq();
    checks++; if ({seq_ok, pan_pos, tilt_pos} !== {1'b1, 8'd131, 8'd127}) begin errors++; $display("[TB] FAIL deadband_65: got done=%b pos %0d/%0d expected 1 131/127", seq_ok, pan_pos, tilt_pos); end
  endtask

  task automatic test_pan_saturation();
    int bad = 0;
    set_vals(2000, 1000, 2000, 1000);
    for (int i = 0; i < 61; i++) begin run_seq(); if (!seq_ok) bad++; end
    checks++; if (pan_pos !== 8'd253) begin errors++; $display("[TB] FAIL pan_near_max: got %0d expected 253", pan_pos); end
    run_seq(); if (!seq_ok) bad++;
    checks++; if (pan_pos !== 8'd255) begin errors++; $display("[TB] FAIL pan_max: got %0d expected 255", pan_pos); end
    for (int i = 0; i < 2; i++) begin run_seq(); if (!seq_ok) bad++; end
    checks++; if (pan_pos !== 8'd255) begin errors++; $display("[TB] FAIL pan_hold_max: got %0d expected 255", pan_pos); end
    checks++; if (tilt_pos !== 8'd127) begin errors++; $display("[TB] FAIL pan_sat_tilt: got %0d expected 127", tilt_pos); end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL pan_sat_runs: got %0d stuck sequences expected 0", bad); end
  endtask

  task automatic test_tilt_saturation();
    int bad = 0;
    set_vals(1000, 1000, 1040, 1040);
    for (int i = 0; i < 63; i++) begin run_seq(); if (!seq_ok) bad++; end
    checks++; if (tilt_pos !== 8'd1) begin errors++; $display("[TB] FAIL tilt_at_one: got %0d expected 1", tilt_pos); end
    run_seq(); if (!seq_ok) bad++;
    checks++; if (tilt_pos !== 8'd0) begin errors++; $display("[TB] FAIL tilt_min: got %0d expected 0", tilt_pos); end
    run_seq(); if (!seq_ok) bad++;
    checks++; if (tilt_pos !== 8'd0) begin errors++; $display("[TB] FAIL tilt_no_wrap: got %0d expected 0", tilt_pos); end
    checks++; if (pan_pos !== 8'd255) begin errors++; $display("[TB] FAIL tilt_sat_pan: got %0d expected 255", pan_pos); end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL tilt_sat_runs: got %0d stuck sequences expected 0", bad); end
  endtask

  task automatic test_reverse();
    set_vals(1000, 1100, 900, 1000);
    run_seq();
    checks++; if ({seq_ok, pan_pos, tilt_pos} !== {1'b1, 8'd253, 8'd2}) begin errors++; $display("[TB] FAIL reverse_pos: got done=%b pos %0d/%0d expected 1 253/2", seq_ok, pan_pos, tilt_pos); end
  endtask

  task automatic test_timeout();
    int n;
    int err_at = -1;
    int err_count = 0;
    logic [3:0] flags_at_20 = 4'hF;
    stall[2] = 1'b1;
    ch_log.delete();
    enable = 1'b1;
    n = 0;
    while (!(adc_req && adc_ch == 2'd2) && n < 80) begin @(posedge clk); #1; n++; end
    enable = 1'b0;
    checks++; if (!(adc_req && adc_ch == 2'd2)) begin errors++; $display("[TB] FAIL timeout_ch2_req: got req=%b ch=%0d expected 1/2", adc_req, adc_ch); end
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (timeout_err) begin err_count++; if (err_at < 0) err_at = k; end
      if (k == 20) flags_at_20 = {adc_req, adc_ch, busy};
    end
    checks++; if (err_at !== 20) begin errors++; $display("[TB] FAIL timeout_when: got pulse at cycle %0d expected 20", err_at); end
    checks++; if (err_count !== 1) begin errors++; $display("[TB] FAIL timeout_width: got %0d cycles expected 1", err_count); end
    checks++; if (flags_at_20 !== 4'b0000) begin errors++; $display("[TB] FAIL timeout_drop: got req/ch/busy %b expected 0000", flags_at_20); end
    checks++; if ({pan_pos, tilt_pos} !== {8'd253, 8'd2}) begin errors++; $display("[TB] FAIL timeout_pos: got %0d/%0d expected 253/2", pan_pos, tilt_pos); end
    stall[2] = 1'b0;
    run_seq();
    checks++; if ({seq_ok, log_code()} !== {1'b1, 32'd1234}) begin errors++; $display("[TB] FAIL timeout_restart: got done=%b code %0d expected 1 1234", seq_ok, log_code()); end
    checks++; if ({pan_pos, tilt_pos} !== {8'd251, 8'd4}) begin errors++; $display("[TB] FAIL timeout_next_pos: got %0d/%0d expected 251/4", pan_pos, tilt_pos); end
  endtask

  task automatic test_ignored_ack();
    int busy_seen = 0;
    enable = 1'b0;
    @(negedge clk);
    adc_data = 12'hFFF;
    adc_ack  = 1'b1;
    @(negedge clk);
    adc_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; if (busy || timeout_err) busy_seen++; end
    checks++; if (busy_seen !== 0) begin errors++; $display("[TB] FAIL stray_ack_busy: got %0d active cycles expected 0", busy_seen); end
    checks++; if ({pan_pos, tilt_pos} !== {8'd251, 8'd4}) begin errors++; $display("[TB] FAIL stray_ack_pos: got %0d/%0d expected 251/4", pan_pos, tilt_pos); end
  endtask

  task automatic test_reset_mid();
    int n;
    set_vals(1000, 1100, 900, 1000);
    ch_log.delete();
    enable = 1'b1;
    n = 0;
    while (!(adc_req && adc_ch == 2'd1) && n < 80) begin @(posedge clk); #1; n++; end
    checks++; if (!(adc_req && adc_ch == 2'd1)) begin errors++; $display("[TB] FAIL rstmid_ch1_req: got req=%b ch=%0d expected 1/1", adc_req, adc_ch); end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({adc_req, adc_ch, busy} !== 4'b0000) begin errors++; $display("[TB] FAIL rstmid_async: got req/ch/busy %b expected 0000", {adc_req, adc_ch, busy}); end
    checks++; if ({pan_pos, tilt_pos} !== {8'd127, 8'd127}) begin errors++; $display("[TB] FAIL rstmid_pos: got %0d/%0d expected 127/127", pan_pos, tilt_pos); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ch_log.delete();
    n = 0;
    while (!busy && n < 30) begin @(posedge clk); #1; n++; end
    enable = 1'b0;
    checks++; if (n !== 10) begin errors++; $display("[TB] FAIL rstmid_resume: got start after %0d cycles expected 10", n); end
    n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if ({busy, log_code()} !== {1'b0, 32'd1234}) begin errors++; $display("[TB] FAIL rstmid_seq: got busy=%b code %0d expected 0 1234", busy, log_code()); end
    checks++; if ({pan_pos, tilt_pos} !== {8'd125, 8'd129}) begin errors++; $display("[TB] FAIL rstmid_next_pos: got %0d/%0d expected 125/129", pan_pos, tilt_pos); end
  endtask

  task automatic test_enable_drop();
    int n;
    int req_cycles = 0;
    set_vals(2000, 1000, 2000, 1000);
    ch_log.delete();
    enable = 1'b1;
    n = 0;
    while (!(adc_req && adc_ch == 2'd3) && n < 80) begin @(posedge clk); #1; n++; end
    enable = 1'b0;
    checks++; if (!(adc_req && adc_ch == 2'd3)) begin errors++; $display("[TB] FAIL endrop_ch3_req: got req=%b ch=%0d expected 1/3", adc_req, adc_ch); end
    n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    checks++; if ({busy, log_code()} !== {1'b0, 32'd1234}) begin errors++; $display("[TB] FAIL endrop_seq: got busy=%b code %0d expected 0 1234", busy, log_code()); end
    checks++; if ({pan_pos, tilt_pos} !== {8'd127, 8'd129}) begin errors++; $display("[TB] FAIL endrop_pos: got %0d/%0d expected 127/129", pan_pos, tilt_pos); end
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (adc_req || busy) req_cycles++; end
    checks++; if (req_cycles !== 0) begin errors++; $display("[TB] FAIL endrop_no_restart: got %0d active cycles expected 0", req_cycles); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      stall[i]   = 1'b0;
      adc_val[i] = '0;
    end
    test_reset();
    test_equal_light();
    test_update_timing();
    test_deadband();
    test_pan_saturation();
    test_tilt_saturation();
    test_reverse();
    test_timeout();
    test_ignored_ack();
    test_reset_mid();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tracker_ctrl.md
TRACKER_CTRL -- requirements
Module: tracker_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter UPDATE_MS, default 100, tracking period in ms; UPDATE_CYCLES = (CLK_FREQ_HZ/1000)*UPDATE_MS.
REQ-003 SHALL have parameter DEADBAND, default 64, minimum absolute light imbalance (ADC counts) that causes movement.
REQ-004 SHALL have parameter STEP, default 2, position increment per update.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1000, maximum wait for adc_ack per channel.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, with ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  tracking permitted when high
adc_req  out  1  conversion request to ADC front end
adc_ch  out  2  LDR channel: 0=TL, 1=TR, 2=BL, 3=BR
adc_ack  in  1  conversion done; adc_data valid this cycle
adc_data  in  12  unsigned LDR reading
pan_pos  out  8  target_pos for the azimuth servo driver
tilt_pos  out  8  target_pos for the elevation servo driver
busy  out  1  high in any state other than WAIT_TICK
timeout_err  out  1  one-cycle pulse on an aborted acquisition

Function
REQ-007 SHALL run a free-running tick counter 0..UPDATE_CYCLES-1 with tick high for one cycle at UPDATE_CYCLES-1, independent of FSM state.
REQ-008 SHALL implement states WAIT_TICK, REQ, WAIT_ACK, CALC, UPDATE.
REQ-009 WAIT_TICK -> REQ on a cycle with tick=1 and enable=1, with the channel index set to 0; a tick seen in any other state SHALL be dropped, not queued.
REQ-010 In REQ and WAIT_ACK, adc_req SHALL be 1 and adc_ch SHALL equal the current index, held stable until adc_ack is sampled 1.
REQ-011 On adc_ack=1 in WAIT_ACK, SHALL capture adc_data into the slot for the current index, drive adc_req 0 on the next cycle, then go to REQ with index+1, or to CALC after index 3.
REQ-012 adc_ack while adc_req=0 SHALL be ignored.
REQ-013 SHALL count cycles in WAIT_ACK per channel; on reaching TIMEOUT_CYCLES, SHALL go to WAIT_TICK, pulse timeout_err for one cycle, drop adc_req, and leave pan_pos and tilt_pos unchanged.
REQ-014 CALC SHALL compute h = (TL+BL)-(TR+BR) and v = (TL+TR)-(BL+BR) as 14-bit signed values from 13-bit unsigned sums, with no overflow possible.
REQ-015 UPDATE SHALL apply these pan rules:
- h > DEADBAND: pan += STEP.
- h < -DEADBAND: pan -= STEP.
- otherwise: no change.
REQ-016 UPDATE SHALL apply these tilt rules:
- v > DEADBAND: tilt += STEP.
- v < -DEADBAND: tilt -= STEP.
- otherwise: no change.
REQ-017 Position arithmetic SHALL be 9-bit, saturating at 255 and 0, and never wrap.
REQ-018 pan_pos and tilt_pos SHALL change only on the UPDATE->WAIT_TICK transition, 2 cycles after the cycle of the fourth adc_ack.
REQ-019 Deasserting enable mid-sequence SHALL NOT abort it; the sequence completes including UPDATE, and no new sequence starts while enable=0.
REQ-020 adc_ch SHALL read 0 when adc_req=0.

Reset
REQ-021 While reset_n=0, SHALL force the following:
- state WAIT_TICK, tick counter 0, channel index 0, timeout counter 0, all sample slots 0.
- adc_req 0, adc_ch 0, busy 0, timeout_err 0.
- pan_pos 127 and tilt_pos 127, matching the servo driver's centre start.
REQ-022 Reset asserted mid-sequence SHALL abort it immediately with no position update; after release, operation SHALL resume at the next tick.

Verification (CLK_FREQ_HZ=1000, UPDATE_MS=10, i.e. 10-cycle period; TIMEOUT_CYCLES=20, DEADBAND=64, STEP=2)
REQ-023 Reset release, enable=1, ADC acks each request after 3 cycles with TL=TR=BL=BR=1000 -> adc_ch sequence 0,1,2,3; pan_pos=tilt_pos=127 after UPDATE.
REQ-024 TL=BL=2000, TR=BR=1000 (h=+2000, v=0) -> pan_pos 129 two cycles after the fourth ack, tilt_pos 127; after 64 such updates pan_pos holds at 255.
REQ-025 TL=TR=1000, BL=BR=1040 (v=-80); start from tilt 1 -> tilt_pos 0 after one update, then stays 0 (no wrap).
REQ-026 h=+64 exactly -> no pan change; h=+65 -> pan +2.
REQ-027 ADC never acks channel 2 -> timeout_err pulses once 20 cycles after adc_req rises for channel 2; positions unchanged; the next tick starts again at channel 0.
REQ-028 reset_n pulsed low during WAIT_ACK for channel 1 -> adc_req 0 and positions 127 without waiting for a clock edge; enable dropped during channel 3 -> UPDATE still occurs and no further adc_req follows.
